// File: rtl/up_csr_regs_if.sv
// Microprocessor bus between the SPI-to-bus master and the CSR bank.
// Strobes are levels, and each rising edge of a strobe is one access.
// Read data comes back one cycle after the read edge.
interface up_csr_regs_if;
  logic        up_wr;
  logic        up_rd;
  logic [31:0] up_addr;
  logic [31:0] up_data_wr;
  logic [31:0] up_data_rd;

  modport master (
    output up_wr,
    output up_rd,
    output up_addr,
    output up_data_wr,
    input  up_data_rd
  );

  modport slave (
    input  up_wr,
    input  up_rd,
    input  up_addr,
    input  up_data_wr,
    output up_data_rd
  );
endinterface

// File: rtl/up_csr_regs.sv
// Tester configuration and status register bank on the up_clk bus.
// Holds the enables, frame length, IFG, frame count and start pulse.
// Exposes sticky W1C event status and the live statistics counters.
// A 64-bit counter is read coherently: reading its LO word snapshots the HI
// word into a shadow, and the following HI read returns that shadow.
module up_csr_regs #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE    = 32'h5453_4554,
  parameter logic [15:0] PKT_LEN_RST = 16'd64,
  parameter logic [7:0]  IFG_RST     = 8'd12
) (
  input  logic          up_clk,
  input  logic          up_rst,
  up_csr_regs_if.slave  up_bus,
  output logic          tx_en,
  output logic          rx_en,
  output logic          tx_start,
  output logic [15:0]   tx_pkt_len,
  output logic [7:0]    tx_ifg,
  output logic [31:0]   tx_pkt_num,
  input  logic [7:0]    stat_evt,
  input  logic [63:0]   tx_pkt_cnt,
  input  logic [63:0]   rx_pkt_cnt,
  input  logic [31:0]   rx_err_cnt
);

  // Word offsets within the 64-byte window
  localparam logic [3:0] OFF_ID        = 4'h0;
  localparam logic [3:0] OFF_SCRATCH   = 4'h1;
  localparam logic [3:0] OFF_CTRL      = 4'h2;
  localparam logic [3:0] OFF_PKT_CFG   = 4'h3;
  localparam logic [3:0] OFF_PKT_NUM   = 4'h4;
  localparam logic [3:0] OFF_STATUS    = 4'h5;
  localparam logic [3:0] OFF_TX_CNT_LO = 4'h6;
  localparam logic [3:0] OFF_TX_CNT_HI = 4'h7;
  localparam logic [3:0] OFF_RX_CNT_LO = 4'h8;
  localparam logic [3:0] OFF_RX_CNT_HI = 4'h9;
  localparam logic [3:0] OFF_RX_ERR    = 4'hA;

  logic        up_wr_d;
  logic        up_rd_d;
  logic        wr_acc;
  logic        rd_acc;
  logic        addr_hit;
  logic [3:0]  offset;
  logic        wr_hit;
  logic        rd_hit;
  logic [31:0] rd_mux;
  logic [31:0] rd_data_q;
  logic [31:0] scratch_q;
  logic [7:0]  status_q;
  logic [7:0]  status_clr;
  logic [31:0] tx_hi_q;
  logic [31:0] rx_hi_q;

  assign up_bus.up_data_rd = rd_data_q;

  // Strobe history; reset to 1 so a strobe held through reset is not an edge
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      up_wr_d <= 1'b1;
      up_rd_d <= 1'b1;
    end else begin
      up_wr_d <= up_bus.up_wr;
      up_rd_d <= up_bus.up_rd;
    end
  end

  // Rising-edge access detection and window/alignment decode
  always_comb begin
    wr_acc   = up_bus.up_wr & ~up_wr_d;
    rd_acc   = up_bus.up_rd & ~up_rd_d;
    addr_hit = (up_bus.up_addr[31:6] == BASE_ADDR[31:6]) &&
               (up_bus.up_addr[1:0] == 2'b00);
    offset   = up_bus.up_addr[5:2];
    wr_hit   = wr_acc & addr_hit;
    rd_hit   = rd_acc & addr_hit;
  end

  // Read mux over current register values, so a concurrent write is not seen
  always_comb begin
    rd_mux = 32'h0;
    if (addr_hit) begin
      case (offset)
        OFF_ID:        rd_mux = ID_VALUE;
        OFF_SCRATCH:   rd_mux = scratch_q;
        OFF_CTRL:      rd_mux = {30'h0, rx_en, tx_en};
        OFF_PKT_CFG:   rd_mux = {8'h0, tx_ifg, tx_pkt_len};
        OFF_PKT_NUM:   rd_mux = tx_pkt_num;
        OFF_STATUS:    rd_mux = {24'h0, status_q};
        OFF_TX_CNT_LO: rd_mux = tx_pkt_cnt[31:0];
        OFF_TX_CNT_HI: rd_mux = tx_hi_q;
        OFF_RX_CNT_LO: rd_mux = rx_pkt_cnt[31:0];
        OFF_RX_CNT_HI: rd_mux = rx_hi_q;
        OFF_RX_ERR:    rd_mux = rx_err_cnt;
        default:       rd_mux = 32'h0;
      endcase
    end
  end

  // Registered read data, held until the next accepted read
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      rd_data_q <= 32'h0;
    end else if (rd_acc) begin
      rd_data_q <= rd_mux;
    end
  end

  // HI-word shadows captured when the matching LO word is read
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      tx_hi_q <= 32'h0;
      rx_hi_q <= 32'h0;
    end else if (rd_hit) begin
      if (offset == OFF_TX_CNT_LO) tx_hi_q <= tx_pkt_cnt[63:32];
      if (offset == OFF_RX_CNT_LO) rx_hi_q <= rx_pkt_cnt[63:32];
    end
  end

  // Read/write configuration registers
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      scratch_q  <= 32'h0;
      tx_en      <= 1'b0;
      rx_en      <= 1'b0;
      tx_pkt_len <= PKT_LEN_RST;
      tx_ifg     <= IFG_RST;
      tx_pkt_num <= 32'h0;
    end else if (wr_hit) begin
      case (offset)
        OFF_SCRATCH: scratch_q <= up_bus.up_data_wr;
        OFF_CTRL: begin
          tx_en <= up_bus.up_data_wr[0];
          rx_en <= up_bus.up_data_wr[1];
        end
        OFF_PKT_CFG: begin
          tx_pkt_len <= up_bus.up_data_wr[15:0];
          tx_ifg     <= up_bus.up_data_wr[23:16];
        end
        OFF_PKT_NUM: tx_pkt_num <= up_bus.up_data_wr;
        default: ;
      endcase
    end
  end

  // One-cycle start pulse from a CTRL write with bit 31 set
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      tx_start <= 1'b0;
    end else begin
      tx_start <= wr_hit && (offset == OFF_CTRL) && up_bus.up_data_wr[31];
    end
  end

  // W1C clear mask for STATUS; zero unless STATUS is being written
  always_comb begin
    status_clr = 8'h0;
    if (wr_hit && (offset == OFF_STATUS)) begin
      status_clr = up_bus.up_data_wr[7:0];
    end
  end

  // Sticky event status; a new event beats a simultaneous clear
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      status_q <= 8'h0;
    end else begin
      status_q <= (status_q & ~status_clr) | stat_evt;
    end
  end

endmodule

// File: tb/tb_up_csr_regs.sv
// Testbench for up_csr_regs: directed bring-up sequence followed by random
// bus traffic. Expected read data goes into a scoreboard queue when a read is
// issued and a monitor pops it after each read edge seen on the bus.
module tb_up_csr_regs;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] ID   = 32'h5453_4554;

  logic        up_clk = 1'b0;
  logic        up_rst = 1'b1;
  logic        tx_en;
  logic        rx_en;
  logic        tx_start;
  logic [15:0] tx_pkt_len;
  logic [7:0]  tx_ifg;
  logic [31:0] tx_pkt_num;
  logic [7:0]  stat_evt = 8'h0;
  logic [63:0] tx_cnt   = 64'h0;
  logic [63:0] rx_cnt   = 64'h0;
  logic [31:0] err_cnt  = 32'h0;

  up_csr_regs_if bus ();

  up_csr_regs #(
    .BASE_ADDR   (BASE),
    .ID_VALUE    (ID),
    .PKT_LEN_RST (16'd64),
    .IFG_RST     (8'd12)
  ) dut (
    .up_clk     (up_clk),
    .up_rst     (up_rst),
    .up_bus     (bus.slave),
    .tx_en      (tx_en),
    .rx_en      (rx_en),
    .tx_start   (tx_start),
    .tx_pkt_len (tx_pkt_len),
    .tx_ifg     (tx_ifg),
    .tx_pkt_num (tx_pkt_num),
    .stat_evt   (stat_evt),
    .tx_pkt_cnt (tx_cnt),
    .rx_pkt_cnt (rx_cnt),
    .rx_err_cnt (err_cnt)
  );

  always #5 up_clk = ~up_clk;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] addr;
  } rd_item_t;

  rd_item_t sb_q[$];
  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [31:0] m_scratch;
  logic        m_tx_en;
  logic        m_rx_en;
  logic [15:0] m_len;
  logic [7:0]  m_ifg;
  logic [31:0] m_num;
  logic [7:0]  m_status;
  logic [31:0] m_tx_hi;
  logic [31:0] m_rx_hi;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_hit(input logic [31:0] addr);
    return ((addr >> 6) == (BASE >> 6)) && ((addr % 4) == 0);
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr % 64) / 4);
  endfunction

  function automatic logic [31:0] model_peek(input logic [31:0] addr);
    logic [31:0] v;
    v = 32'h0;
    if (is_hit(addr)) begin
      case (word_of(addr))
        0:  v = ID;
        1:  v = m_scratch;
        2:  v = 32'(m_tx_en) + 32'(m_rx_en) * 2;
        3:  v = 32'(m_len) + 32'(m_ifg) * 65536;
        4:  v = m_num;
        5:  v = 32'(m_status);
        6:  v = tx_cnt[31:0];
        7:  v = m_tx_hi;
        8:  v = rx_cnt[31:0];
        9:  v = m_rx_hi;
        10: v = err_cnt;
        default: v = 32'h0;
      endcase
    end
    return v;
  endfunction

  task automatic model_reset();
    m_scratch = 32'h0;
    m_tx_en   = 1'b0;
    m_rx_en   = 1'b0;
    m_len     = 16'd64;
    m_ifg     = 8'd12;
    m_num     = 32'h0;
    m_status  = 8'h0;
    m_tx_hi   = 32'h0;
    m_rx_hi   = 32'h0;
  endtask

  task automatic checkControls(input string tag);
    checkOutput({tag, " tx_en"}, 64'(tx_en), 64'(m_tx_en));
    checkOutput({tag, " rx_en"}, 64'(rx_en), 64'(m_rx_en));
    checkOutput({tag, " tx_pkt_len"}, 64'(tx_pkt_len), 64'(m_len));
    checkOutput({tag, " tx_ifg"}, 64'(tx_ifg), 64'(m_ifg));
    checkOutput({tag, " tx_pkt_num"}, 64'(tx_pkt_num), 64'(m_num));
  endtask

  task automatic doReset();
    @(negedge up_clk);
    up_rst = 1'b1;
    bus.up_wr = 1'b0;
    bus.up_rd = 1'b0;
    stat_evt = 8'h0;
    repeat (2) @(negedge up_clk);
    up_rst = 1'b0;
    model_reset();
    checkOutput("reset up_data_rd", 64'(bus.up_data_rd), 64'h0);
    checkOutput("reset tx_start", 64'(tx_start), 64'h0);
    checkControls("reset");
  endtask

  // One bus access (read, write, both, or idle) lasting hold cycles, with an
  // optional event pulse in its first cycle, followed by one idle cycle.
  task automatic applyStimulus(input bit do_wr, input bit do_rd, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [7:0] evt, input int hold);
    bit pulse;
    @(negedge up_clk);
    pulse = 1'b0;
    if (do_rd) begin
      sb_q.push_back('{exp: model_peek(addr), addr: addr});
      if (is_hit(addr) && word_of(addr) == 6) m_tx_hi = tx_cnt[63:32];
      if (is_hit(addr) && word_of(addr) == 8) m_rx_hi = rx_cnt[63:32];
    end
    if (do_wr && is_hit(addr)) begin
      case (word_of(addr))
        1: m_scratch = wd;
        2: begin
          m_tx_en = wd[0];
          m_rx_en = wd[1];
          pulse   = wd[31];
        end
        3: begin
          m_len = wd[15:0];
          m_ifg = wd[23:16];
        end
        4: m_num = wd;
        5: m_status = m_status & ~wd[7:0];
        default: ;
      endcase
    end
    m_status = m_status | evt;
    bus.up_wr      = do_wr;
    bus.up_rd      = do_rd;
    bus.up_addr    = addr;
    bus.up_data_wr = wd;
    stat_evt       = evt;
    for (int i = 0; i < hold; i++) begin
      @(posedge up_clk);
      #1;
      checkOutput("tx_start", 64'(tx_start), 64'((i == 0) && pulse));
      if (i == 0) checkControls("access");
      @(negedge up_clk);
      stat_evt = 8'h0;
    end
    bus.up_wr = 1'b0;
    bus.up_rd = 1'b0;
    @(posedge up_clk);
    #1;
    checkOutput("tx_start idle", 64'(tx_start), 64'h0);
  endtask

  // Read monitor: tracks read edges on the bus and checks returned data
  logic rd_prev = 1'b1;
  logic rd_fire;
  rd_item_t item;
  always @(posedge up_clk) begin
    rd_fire = !up_rst && bus.up_rd && !rd_prev;
    rd_prev = up_rst ? 1'b1 : bus.up_rd;
    if (rd_fire) begin
      #1;
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL read without expectation: got 0x%0h expected none", bus.up_data_rd);
      end else begin
        item = sb_q.pop_front();
        checkOutput($sformatf("read addr 0x%0h", item.addr), 64'(bus.up_data_rd), 64'(item.exp));
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] r_addr;
  logic [31:0] r_data;
  int          sel;

  initial begin
    bus.up_wr      = 1'b0;
    bus.up_rd      = 1'b0;
    bus.up_addr    = 32'h0;
    bus.up_data_wr = 32'h0;
    model_reset();
    doReset();

    $display("[TB] reset values and ID");
    applyStimulus(0, 1, 32'h00, 32'h0, 8'h0, 1);
    applyStimulus(0, 1, 32'h0C, 32'h0, 8'h0, 1);

    $display("[TB] scratch, held strobe, unaligned and unmapped");
    applyStimulus(1, 0, 32'h04, 32'hA5A5_5A5A, 8'h0, 5);
    applyStimulus(0, 1, 32'h04, 32'h0, 8'h0, 1);
    applyStimulus(1, 0, 32'h02, 32'h1234_5678, 8'h0, 1);
    applyStimulus(0, 1, 32'h02, 32'h0, 8'h0, 1);
    applyStimulus(0, 1, 32'h04, 32'h0, 8'h0, 1);
    applyStimulus(0, 1, 32'h3C, 32'h0, 8'h0, 1);
    applyStimulus(1, 0, 32'h0000_0044, 32'hFFFF_FFFF, 8'h0, 1);
    applyStimulus(0, 1, 32'h0000_0044, 32'h0, 8'h0, 1);

    $display("[TB] control and start pulse");
    applyStimulus(1, 0, 32'h08, 32'h8000_0003, 8'h0, 1);
    applyStimulus(0, 1, 32'h08, 32'h0, 8'h0, 1);

    $display("[TB] sticky status");
    applyStimulus(0, 0, 32'h00, 32'h0, 8'h05, 1);
    applyStimulus(1, 0, 32'h14, 32'h1, 8'h01, 1);
    applyStimulus(0, 1, 32'h14, 32'h0, 8'h0, 1);
    applyStimulus(1, 0, 32'h14, 32'h1, 8'h00, 1);
    applyStimulus(0, 1, 32'h14, 32'h0, 8'h0, 1);

    $display("[TB] coherent counter snapshot");
    tx_cnt = 64'h0000_0001_FFFF_FFFF;
    applyStimulus(0, 1, 32'h18, 32'h0, 8'h0, 1);
    tx_cnt = 64'h0000_0002_0000_0000;
    applyStimulus(0, 1, 32'h1C, 32'h0, 8'h0, 1);
    rx_cnt  = 64'h1234_5678_9ABC_DEF0;
    err_cnt = 32'hCAFE_0001;
    applyStimulus(0, 1, 32'h20, 32'h0, 8'h0, 1);
    rx_cnt  = 64'h0;
    applyStimulus(0, 1, 32'h24, 32'h0, 8'h0, 1);
    applyStimulus(0, 1, 32'h28, 32'h0, 8'h0, 1);

    $display("[TB] simultaneous read and write");
    applyStimulus(1, 1, 32'h04, 32'h1111_2222, 8'h0, 1);
    applyStimulus(0, 1, 32'h04, 32'h0, 8'h0, 1);

    $display("[TB] write held across reset");
    @(negedge up_clk);
    up_rst         = 1'b1;
    bus.up_wr      = 1'b1;
    bus.up_addr    = 32'h04;
    bus.up_data_wr = 32'hDEAD_BEEF;
    repeat (2) @(negedge up_clk);
    up_rst = 1'b0;
    model_reset();
    repeat (3) @(negedge up_clk);
    bus.up_wr = 1'b0;
    applyStimulus(0, 1, 32'h04, 32'h0, 8'h0, 1);

    $display("[TB] reset during start pulse");
    @(negedge up_clk);
    bus.up_wr      = 1'b1;
    bus.up_addr    = 32'h08;
    bus.up_data_wr = 32'h8000_0001;
    @(posedge up_clk);
    #1;
    checkOutput("start before reset", 64'(tx_start), 64'h1);
    @(negedge up_clk);
    up_rst    = 1'b1;
    bus.up_wr = 1'b0;
    @(posedge up_clk);
    #1;
    checkOutput("start after reset", 64'(tx_start), 64'h0);
    checkOutput("tx_en after reset", 64'(tx_en), 64'h0);
    @(negedge up_clk);
    up_rst = 1'b0;
    model_reset();

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 19));
      if (sel < 14)      r_addr = BASE + 32'($urandom_range(0, 15)) * 4;
      else if (sel < 17) r_addr = BASE + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
      else               r_addr = $urandom;
      r_data = $urandom;
      if ($urandom_range(0, 3) == 0) tx_cnt = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rx_cnt = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) err_cnt = $urandom;
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, r_addr, r_data,
                    ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0,
                    int'($urandom_range(1, 3)));
    end

    repeat (3) @(posedge up_clk);
    #1;
    if (sb_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL pending reads: got %0d left expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
